// File: rtl/hyper_pkg.sv
// Shared types and constants for the hypervisor trap/return sequencer.
// States, injected opcodes and hyper register addresses.
package hyper_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        EN_PHP_FETCH = 4'd1,
        EN_PHP_DEC   = 4'd2,
        EN_PHP_EX    = 4'd3,
        EN_JMP_FETCH = 4'd4,
        EN_JMP_L     = 4'd5,
        EN_JMP_H     = 4'd6,
        EX_CLE_FETCH = 4'd7,
        EX_CLE_EX    = 4'd8,
        EX_PLP_FETCH = 4'd9,
        EX_PLP_DEC   = 4'd10,
        EX_PLP_EX    = 4'd11,
        EX_JMP_FETCH = 4'd12,
        EX_JMP_L     = 4'd13,
        EX_JMP_H     = 4'd14
    } hyper_state_t;

    localparam logic [7:0] OP_PHP = 8'h08;
    localparam logic [7:0] OP_PLP = 8'h28;
    localparam logic [7:0] OP_JMP = 8'h4C;
    localparam logic [7:0] OP_CLE = 8'h02;

    localparam logic [7:0] REG_PCL  = 8'h48;
    localparam logic [7:0] REG_PCH  = 8'h49;
    localparam logic [7:0] REG_P    = 8'h4A;
    localparam logic [7:0] REG_PORT = 8'h4B;
    localparam logic [7:0] REG_OVR  = 8'h4C;
    localparam logic [7:0] REG_MAP  = 8'h4D;
    localparam logic [7:0] REG_EXIT = 8'h7F;
    localparam logic [7:0] REG_SAVE = 8'h50;

    // Opcode-fetch states only advance on a cpu_sync cycle.
    function automatic logic is_fetch(hyper_state_t s);
        return (s == EN_PHP_FETCH) || (s == EN_JMP_FETCH) ||
               (s == EX_CLE_FETCH) || (s == EX_PLP_FETCH) ||
               (s == EX_JMP_FETCH);
    endfunction

endpackage

// File: rtl/hyper_snapshot.sv
// Background snapshot of mapper bytes taken on each guest trap.
// One byte per ready cycle; contents survive reset.
module hyper_snapshot #(
    parameter int SAVE_REGS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_ready,
    input  logic [7:0] i_save_data,
    input  logic [2:0] i_rd_idx,
    output logic       o_active,
    output logic [2:0] o_save_sel,
    output logic [7:0] o_rd_data
);

    localparam logic [2:0] LAST = 3'(SAVE_REGS - 1);

    logic       r_active;
    logic [2:0] r_cnt;
    logic [7:0] r_regs [SAVE_REGS];

    // Walk the index across the mapper bytes, one per ready cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= 3'd0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= 3'd0;
        end else if (r_active && i_ready) begin
            if (r_cnt == LAST) begin
                r_active <= 1'b0;
                r_cnt    <= 3'd0;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Capture the selected byte; reset leaves old contents in place.
    always_ff @(posedge clk) begin
        if (!reset && r_active && i_ready) begin
            for (int k = 0; k < SAVE_REGS; k++) begin
                if (r_cnt == 3'(k)) begin
                    r_regs[k] <= i_save_data;
                end
            end
        end
    end

    // Readback; indices past the last saved byte return zero.
    always_comb begin
        o_rd_data = 8'h00;
        for (int k = 0; k < SAVE_REGS; k++) begin
            if (i_rd_idx == 3'(k)) begin
                o_rd_data = r_regs[k];
            end
        end
    end

    assign o_active   = r_active;
    assign o_save_sel = r_cnt;

endmodule

// File: rtl/hyper_trap_seq.sv
// Hypervisor trap/return sequencer on the 4510 data-in bus.
// Injects entry and exit opcode streams and holds saved CPU state.
module hyper_trap_seq
    import hyper_pkg::*;
#(
    parameter int          TRAP_BITS = 6,
    parameter logic [15:0] VEC_BASE  = 16'h8000,
    parameter int          VEC_SHIFT = 2,
    parameter int          SAVE_REGS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_hyper_cs,
    input  logic        i_hyper_we,
    input  logic [7:0]  i_hyper_addr,
    input  logic [7:0]  i_hyper_wdata,
    output logic [7:0]  o_hyper_rdata,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_ext_data_i,
    input  logic [7:0]  i_cpu_data_o,
    input  logic        i_cpu_sync,
    input  logic        i_ready,
    output logic [7:0]  o_cpu_data_i,
    output logic        o_hyper_mode,
    output logic        o_map_enable,
    output logic        o_busy,
    output logic [2:0]  o_save_sel,
    input  logic [7:0]  i_save_data
);

    hyper_state_t r_state;
    hyper_state_t w_next;

    logic                 r_hyper_mode;
    logic                 r_map_gate;
    logic                 r_overrun;
    logic                 r_exit_pend;
    logic [15:0]          r_pc;
    logic [7:0]           r_p;
    logic [TRAP_BITS-1:0] r_port;
    logic [15:0]          r_vec;

    logic                 w_acc;
    logic                 w_idle;
    logic                 w_trap;
    logic                 w_hwr;
    logic                 w_wr_exit;
    logic                 w_exit_req;
    logic                 w_go_exit;
    logic                 w_q;
    logic                 w_inj;
    logic [7:0]           w_inj_byte;
    logic                 w_cap_pc;
    logic                 w_cap_p;
    logic                 w_cle;
    logic                 w_snap_active;
    logic [7:0]           w_snap_rd;
    logic [TRAP_BITS-1:0] w_port;
    logic [15:0]          w_vec;

    assign w_acc  = i_hyper_cs & i_hyper_we & i_ready &
                    (i_hyper_addr[7:6] == 2'b01);
    assign w_idle = (r_state == IDLE);
    assign w_trap = w_acc & w_idle & ~r_hyper_mode;
    assign w_hwr  = w_acc & w_idle & r_hyper_mode;

    assign w_wr_exit  = w_hwr & (i_hyper_addr == REG_EXIT);
    assign w_exit_req = r_exit_pend | w_wr_exit;

    assign w_port = i_hyper_addr[TRAP_BITS-1:0];
    assign w_vec  = VEC_BASE | (16'(w_port) << VEC_SHIFT);

    assign w_q = i_ready & (~is_fetch(r_state) | i_cpu_sync);

    // Next state and injected byte for the current cycle.
    always_comb begin
        w_next     = r_state;
        w_inj      = 1'b0;
        w_inj_byte = 8'h00;
        w_cap_pc   = 1'b0;
        w_cap_p    = 1'b0;
        w_cle      = 1'b0;
        w_go_exit  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trap) begin
                    w_next = EN_PHP_FETCH;
                end else if (w_exit_req && !w_snap_active && i_ready) begin
                    w_go_exit = 1'b1;
                    w_next    = EX_CLE_FETCH;
                end
            end
            EN_PHP_FETCH: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = OP_PHP;
                w_cap_pc   = 1'b1;
                w_next     = EN_PHP_DEC;
            end
            EN_PHP_DEC: if (w_q) begin
                w_next = EN_PHP_EX;
            end
            EN_PHP_EX: if (w_q) begin
                w_cap_p = 1'b1;
                w_next  = EN_JMP_FETCH;
            end
            EN_JMP_FETCH: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = OP_JMP;
                w_next     = EN_JMP_L;
            end
            EN_JMP_L: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = r_vec[7:0];
                w_next     = EN_JMP_H;
            end
            EN_JMP_H: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = r_vec[15:8];
                w_next     = IDLE;
            end
            EX_CLE_FETCH: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = OP_CLE | {7'b0, r_p[5]};
                w_cle      = 1'b1;
                w_next     = EX_CLE_EX;
            end
            EX_CLE_EX: if (w_q) begin
                w_next = EX_PLP_FETCH;
            end
            EX_PLP_FETCH: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = OP_PLP;
                w_next     = EX_PLP_DEC;
            end
            EX_PLP_DEC: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = r_p;
                w_next     = EX_PLP_EX;
            end
            EX_PLP_EX: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = r_p;
                w_next     = EX_JMP_FETCH;
            end
            EX_JMP_FETCH: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = OP_JMP;
                w_next     = EX_JMP_L;
            end
            EX_JMP_L: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = r_pc[7:0];
                w_next     = EX_JMP_H;
            end
            EX_JMP_H: if (w_q) begin
                w_inj      = 1'b1;
                w_inj_byte = r_pc[15:8];
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Mode, map gate, overrun and held-exit flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hyper_mode <= 1'b0;
            r_map_gate   <= 1'b1;
            r_overrun    <= 1'b0;
            r_exit_pend  <= 1'b0;
        end else begin
            if (w_trap) begin
                r_hyper_mode <= 1'b1;
                r_map_gate   <= 1'b0;
            end else if (w_cle) begin
                r_hyper_mode <= 1'b0;
                r_map_gate   <= 1'b1;
            end else if (w_hwr && i_hyper_addr == REG_MAP) begin
                r_map_gate <= i_hyper_wdata[0];
            end
            if (w_acc && !w_idle) begin
                r_overrun <= 1'b1;
            end else if (w_hwr && i_hyper_addr == REG_OVR) begin
                r_overrun <= 1'b0;
            end
            if (w_go_exit) begin
                r_exit_pend <= 1'b0;
            end else if (w_exit_req) begin
                r_exit_pend <= 1'b1;
            end
        end
    end

    // Saved CPU state; deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_trap) begin
                r_port <= w_port;
                r_vec  <= w_vec;
            end
            if (w_cap_pc) begin
                r_pc <= i_cpu_addr;
            end else if (w_hwr && i_hyper_addr == REG_PCL) begin
                r_pc[7:0] <= i_hyper_wdata;
            end else if (w_hwr && i_hyper_addr == REG_PCH) begin
                r_pc[15:8] <= i_hyper_wdata;
            end
            if (w_cap_p) begin
                r_p <= i_cpu_data_o;
            end else if (w_hwr && i_hyper_addr == REG_P) begin
                r_p <= i_hyper_wdata;
            end
        end
    end

    hyper_snapshot #(
        .SAVE_REGS(SAVE_REGS)
    ) u_snap (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_trap),
        .i_ready    (i_ready),
        .i_save_data(i_save_data),
        .i_rd_idx   (i_hyper_addr[2:0]),
        .o_active   (w_snap_active),
        .o_save_sel (o_save_sel),
        .o_rd_data  (w_snap_rd)
    );

    // Hyper register readback.
    always_comb begin
        o_hyper_rdata = 8'h00;
        unique case (1'b1)
            (i_hyper_addr == REG_PCL):  o_hyper_rdata = r_pc[7:0];
            (i_hyper_addr == REG_PCH):  o_hyper_rdata = r_pc[15:8];
            (i_hyper_addr == REG_P):    o_hyper_rdata = r_p;
            (i_hyper_addr == REG_PORT): o_hyper_rdata = 8'(r_port);
            (i_hyper_addr == REG_OVR):  o_hyper_rdata = {7'b0, r_overrun};
            (i_hyper_addr[7:3] == REG_SAVE[7:3]):
                o_hyper_rdata = w_snap_rd;
            default: o_hyper_rdata = 8'h00;
        endcase
    end

    assign o_cpu_data_i = w_inj ? w_inj_byte : i_cpu_ext_data_i;
    assign o_hyper_mode = r_hyper_mode;
    assign o_map_enable = r_map_gate & w_idle;
    assign o_busy       = ~w_idle | w_snap_active;

endmodule

// File: tb/tb_hyper_trap_seq.sv
// Directed bench for hyper_trap_seq: entry/exit streams, readback,
// ready stalls, overrun, held exit and mid-sequence reset.
module tb_hyper_trap_seq;

    typedef struct {
        logic        cs;
        logic        we;
        logic        rdy;
        logic        sync;
        logic [7:0]  addr;
        logic [15:0] ca;
        logic [7:0]  dout;
        logic [7:0]  e_data;
        logic        e_hm;
        logic        e_me;
        logic        e_busy;
        logic [2:0]  e_sel;
    } row_t;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [15:0] ca;
    logic [7:0]  ext;
    logic [7:0]  dout;
    logic        sync;
    logic        rdy;

    logic [7:0]  rdata, cdi, sd;
    logic        hm, me, busy;
    logic [2:0]  sel;
    logic [7:0]  rdata8, cdi8, sd8;
    logic        hm8, me8, busy8;
    logic [2:0]  sel8;

    int n_chk;
    int n_pass;

    row_t ent [8];
    row_t ex  [11];

    assign sd  = 8'h10 + {5'b0, sel};
    assign sd8 = 8'h10 + {5'b0, sel8};

    hyper_trap_seq u_dut (
        .clk             (clk),
        .reset           (reset),
        .i_hyper_cs      (cs),
        .i_hyper_we      (we),
        .i_hyper_addr    (addr),
        .i_hyper_wdata   (wdata),
        .o_hyper_rdata   (rdata),
        .i_cpu_addr      (ca),
        .i_cpu_ext_data_i(ext),
        .i_cpu_data_o    (dout),
        .i_cpu_sync      (sync),
        .i_ready         (rdy),
        .o_cpu_data_i    (cdi),
        .o_hyper_mode    (hm),
        .o_map_enable    (me),
        .o_busy          (busy),
        .o_save_sel      (sel),
        .i_save_data     (sd)
    );

    hyper_trap_seq #(.SAVE_REGS(8)) u_dut8 (
        .clk             (clk),
        .reset           (reset),
        .i_hyper_cs      (cs),
        .i_hyper_we      (we),
        .i_hyper_addr    (addr),
        .i_hyper_wdata   (wdata),
        .o_hyper_rdata   (rdata8),
        .i_cpu_addr      (ca),
        .i_cpu_ext_data_i(ext),
        .i_cpu_data_o    (dout),
        .i_cpu_sync      (sync),
        .i_ready         (rdy),
        .o_cpu_data_i    (cdi8),
        .o_hyper_mode    (hm8),
        .o_map_enable    (me8),
        .o_busy          (busy8),
        .o_save_sel      (sel8),
        .i_save_data     (sd8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(
        input logic cs_i, input logic sync_i, input logic [7:0] a,
        input logic [15:0] c, input logic [7:0] d, input logic [7:0] ed,
        input logic h, input logic m, input logic b, input logic [2:0] s
    );
        row_t r;
        r.cs = cs_i; r.we = cs_i; r.rdy = 1'b1; r.sync = sync_i;
        r.addr = a; r.ca = c; r.dout = d; r.e_data = ed;
        r.e_hm = h; r.e_me = m; r.e_busy = b; r.e_sel = s;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic apply(input row_t r, input string nm);
        @(negedge clk);
        cs = r.cs; we = r.we; rdy = r.rdy; sync = r.sync;
        addr = r.addr; wdata = 8'h00; ca = r.ca; dout = r.dout;
        #1;
        chk({nm, ".data"}, 16'(cdi), 16'(r.e_data));
        chk({nm, ".hm"},   16'(hm),  16'(r.e_hm));
        chk({nm, ".me"},   16'(me),  16'(r.e_me));
        chk({nm, ".busy"}, 16'(busy), 16'(r.e_busy));
        chk({nm, ".sel"},  16'(sel), 16'(r.e_sel));
    endtask

    task automatic idle();
        @(negedge clk);
        cs = 0; we = 0; rdy = 1; sync = 0; addr = 8'h00;
        ca = 16'hBEEF; dout = 8'h00;
    endtask

    task automatic hwr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1; we = 1; rdy = 1; sync = 0; addr = a; wdata = d;
        idle();
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input logic use8, input string nm);
        @(negedge clk);
        cs = 1; we = 0; rdy = 1; sync = 0; addr = a;
        #1;
        chk(nm, 16'(use8 ? rdata8 : rdata), 16'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; cs = 0; we = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1; cs = 0; we = 0; addr = 0; wdata = 0;
        ca = 16'hBEEF; ext = 8'hEA; dout = 0; sync = 0; rdy = 1;

        ent[0] = mk(1, 0, 8'h45, 16'hBEEF, 8'h00, 8'hEA, 0, 1, 0, 0);
        ent[1] = mk(0, 1, 8'h00, 16'h1234, 8'h00, 8'h08, 1, 0, 1, 0);
        ent[2] = mk(0, 0, 8'h00, 16'hBEEF, 8'hA5, 8'hEA, 1, 0, 1, 1);
        ent[3] = mk(0, 0, 8'h00, 16'hBEEF, 8'hA5, 8'hEA, 1, 0, 1, 2);
        ent[4] = mk(0, 1, 8'h00, 16'hBEEF, 8'h00, 8'h4C, 1, 0, 1, 3);
        ent[5] = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'h14, 1, 0, 1, 0);
        ent[6] = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'h80, 1, 0, 1, 0);
        ent[7] = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'hEA, 1, 0, 0, 0);

        ex[0]  = mk(1, 0, 8'h7F, 16'hBEEF, 8'h00, 8'hEA, 1, 0, 0, 0);
        ex[1]  = mk(0, 1, 8'h00, 16'hBEEF, 8'h00, 8'h03, 1, 0, 1, 0);
        ex[2]  = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'hEA, 0, 0, 1, 0);
        ex[3]  = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'hEA, 0, 0, 1, 0);
        ex[4]  = mk(0, 1, 8'h00, 16'hBEEF, 8'h00, 8'h28, 0, 0, 1, 0);
        ex[5]  = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'hA5, 0, 0, 1, 0);
        ex[6]  = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'hA5, 0, 0, 1, 0);
        ex[7]  = mk(0, 1, 8'h00, 16'hBEEF, 8'h00, 8'h4C, 0, 0, 1, 0);
        ex[8]  = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'h34, 0, 0, 1, 0);
        ex[9]  = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'h12, 0, 0, 1, 0);
        ex[10] = mk(0, 0, 8'h00, 16'hBEEF, 8'h00, 8'hEA, 0, 1, 0, 0);

        // Reset state
        do_reset();
        #1;
        chk("rst.data", 16'(cdi), 16'hEA);
        chk("rst.hm", 16'(hm), 16'd0);
        chk("rst.me", 16'(me), 16'd1);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.sel", 16'(sel), 16'd0);
        rd(8'h4C, 8'h00, 0, "rst.ovr");

        // Trap entry and readback
        for (int i = 0; i < 8; i++) apply(ent[i], $sformatf("ent%0d", i));
        rd(8'h48, 8'h34, 0, "rd.pcl");
        rd(8'h49, 8'h12, 0, "rd.pch");
        rd(8'h4A, 8'hA5, 0, "rd.p");
        rd(8'h4B, 8'h05, 0, "rd.port");
        rd(8'h4C, 8'h00, 0, "rd.ovr");
        for (int i = 0; i < 4; i++)
            rd(8'h50 + 8'(i), 8'h10 + 8'(i), 0, $sformatf("rd.save%0d", i));
        rd(8'h54, 8'h00, 0, "rd.save4_out");
        rd(8'h4D, 8'h00, 0, "rd.other");
        rd(8'h57, 8'h17, 1, "rd8.save7");

        // Hyper-mode register writes
        hwr(8'h4D, 8'h01);
        #1 chk("mapgate.on", 16'(me), 16'd1);
        hwr(8'h4D, 8'h00);
        #1 chk("mapgate.off", 16'(me), 16'd0);
        hwr(8'h48, 8'h78);
        rd(8'h48, 8'h78, 0, "wr.pcl");
        hwr(8'h48, 8'h34);
        hwr(8'h4A, 8'h5A);
        rd(8'h4A, 8'h5A, 0, "wr.p");
        hwr(8'h4A, 8'hA5);

        // Exit sequence, including a fetch-wait cycle
        for (int i = 0; i < 11; i++) apply(ex[i], $sformatf("ex%0d", i));

        // Entry with ready low every other cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            row_t st;
            if (i > 0) begin
                st = ent[i];
                st.rdy = 0; st.sync = 1; st.ca = 16'h5555;
                st.e_data = 8'hEA;
                apply(st, $sformatf("stall%0d", i));
            end
            apply(ent[i], $sformatf("rdy%0d", i));
        end
        rd(8'h48, 8'h34, 0, "rdy.pcl");
        rd(8'h53, 8'h13, 0, "rdy.save3");

        // Trap write while the entry stream runs
        do_reset();
        for (int i = 0; i < 8; i++) begin
            row_t r;
            r = ent[i];
            if (i == 5) begin
                r.cs = 1; r.we = 1; r.addr = 8'h47;
            end
            apply(r, $sformatf("ovr%0d", i));
        end
        rd(8'h4C, 8'h01, 0, "ovr.set");
        rd(8'h4B, 8'h05, 0, "ovr.port");
        hwr(8'h4C, 8'h00);
        rd(8'h4C, 8'h00, 0, "ovr.clr");

        // Exit held behind a longer snapshot
        do_reset();
        for (int i = 0; i < 7; i++) apply(ent[i], $sformatf("hold%0d", i));
        @(negedge clk);
        cs = 1; we = 1; addr = 8'h7F; sync = 0; rdy = 1; ca = 16'hBEEF;
        #1;
        chk("hold7.busy8", 16'(busy8), 16'd1);
        chk("hold7.hm8", 16'(hm8), 16'd1);
        @(negedge clk);
        cs = 0; we = 0; sync = 1;
        #1;
        chk("hold8.busy8", 16'(busy8), 16'd1);
        chk("hold8.data8", 16'(cdi8), 16'hEA);
        chk("hold8.data4", 16'(cdi), 16'h03);
        @(negedge clk);
        #1;
        chk("hold9.busy8", 16'(busy8), 16'd0);
        chk("hold9.data8", 16'(cdi8), 16'hEA);
        @(negedge clk);
        #1;
        chk("hold10.data8", 16'(cdi8), 16'h03);
        chk("hold10.busy8", 16'(busy8), 16'd1);
        rd(8'h57, 8'h00, 0, "hold.save7_out");

        // Reset during EX_PLP_DEC
        do_reset();
        for (int i = 0; i < 8; i++) apply(ent[i], $sformatf("rm%0d", i));
        for (int i = 0; i < 5; i++) apply(ex[i], $sformatf("rmx%0d", i));
        @(negedge clk);
        reset = 1; cs = 0; we = 0; sync = 0;
        @(negedge clk);
        reset = 0;
        #1;
        chk("rm.data", 16'(cdi), 16'hEA);
        chk("rm.hm", 16'(hm), 16'd0);
        chk("rm.me", 16'(me), 16'd1);
        chk("rm.busy", 16'(busy), 16'd0);
        rd(8'h48, 8'h34, 0, "rm.pcl");
        rd(8'h4A, 8'hA5, 0, "rm.p");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
